// File: rtl/core_pkg.sv
// Shared decode constants and ALU operation encoding for the RV32I integer slice.
// Imported by fetch, decode_execute, alu and the top level.
package core_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP  = 32'd4;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_op_t;

   // alt picks SUB over ADD and SRA over SRL; callers decide when alt is meaningful
   function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU; shifts use only the low five bits of b.
module alu
   import core_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  alu_op_t     i_op,
   output logic [31:0] o_y
);

   logic [4:0] w_shamt;

   assign w_shamt = i_b[4:0];

   always_comb begin
      o_y = '0;
      case (i_op)
         ALU_ADD:  o_y = i_a + i_b;
         ALU_SUB:  o_y = i_a - i_b;
         ALU_SLL:  o_y = i_a << w_shamt;
         ALU_SLT:  o_y = {31'd0, ($signed(i_a) < $signed(i_b))};
         ALU_SLTU: o_y = {31'd0, (i_a < i_b)};
         ALU_XOR:  o_y = i_a ^ i_b;
         ALU_SRL:  o_y = i_a >> w_shamt;
         ALU_SRA:  o_y = $unsigned($signed(i_a) >>> w_shamt);
         ALU_OR:   o_y = i_a | i_b;
         ALU_AND:  o_y = i_a & i_b;
         default:  o_y = '0;
      endcase
   end

endmodule

// File: rtl/decode_execute.sv
// Decode/execute stage: decodes OP, OP-IMM, LUI and AUIPC, runs the ALU and
// writes the 32x32 register file on the same edge that registers the result.
module decode_execute
   import core_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_instr_pc,
   output logic [31:0] o_result,
   output logic        o_reg_write_enable,
   output logic [4:0]  o_rd_addr
);

   logic [6:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [2:0]  w_funct3;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [6:0]  w_funct7;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_u;
   logic [31:0] w_rs1_data;
   logic [31:0] w_rs2_data;
   logic [31:0] w_alu_a;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_y;
   alu_op_t     w_alu_op;
   logic        w_valid;

   logic [31:0] r_regs [0:31];
   logic [31:0] r_result;
   logic        r_we;
   logic [4:0]  r_rd;

   assign w_opcode = i_instr[6:0];
   assign w_rd     = i_instr[11:7];
   assign w_funct3 = i_instr[14:12];
   assign w_rs1    = i_instr[19:15];
   assign w_rs2    = i_instr[24:20];
   assign w_funct7 = i_instr[31:25];
   assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_imm_u  = {i_instr[31:12], 12'd0};

   // Entry 0 is never written; the read mux supplies the hardwired zero
   assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
   assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

   always_comb begin
      w_valid  = 1'b0;
      w_alu_op = ALU_ADD;
      w_alu_a  = w_rs1_data;
      w_alu_b  = w_rs2_data;
      case (w_opcode)
         OPC_OP: begin
            w_alu_op = alu_op_from_f3(w_funct3, w_funct7[5]);
            w_valid  = (w_funct7 == F7_BASE) ||
                       ((w_funct7 == F7_ALT) && ((w_funct3 == F3_ADD) || (w_funct3 == F3_SR)));
         end
         OPC_OP_IMM: begin
            // Only the right-shift immediates carry an opcode-extension bit
            w_alu_b  = w_imm_i;
            w_alu_op = alu_op_from_f3(w_funct3, (w_funct3 == F3_SR) && w_funct7[5]);
            case (w_funct3)
               F3_SLL:  w_valid = (w_funct7 == F7_BASE);
               F3_SR:   w_valid = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
               default: w_valid = 1'b1;
            endcase
         end
         OPC_LUI: begin
            w_alu_a = 32'd0;
            w_alu_b = w_imm_u;
            w_valid = 1'b1;
         end
         OPC_AUIPC: begin
            w_alu_a = i_instr_pc;
            w_alu_b = w_imm_u;
            w_valid = 1'b1;
         end
         default: w_valid = 1'b0;
      endcase
   end

   alu u_alu (
      .i_a  (w_alu_a),
      .i_b  (w_alu_b),
      .i_op (w_alu_op),
      .o_y  (w_alu_y)
   );

   // Contents survive reset; the reset-cleared instruction is invalid, so no write fires
   always_ff @(posedge i_clk) begin
      if (w_valid && (w_rd != 5'd0)) begin
         r_regs[w_rd] <= w_alu_y;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_result <= '0;
         r_we     <= 1'b0;
         r_rd     <= '0;
      end else begin
         r_result <= w_valid ? w_alu_y : 32'd0;
         r_we     <= w_valid;
         r_rd     <= w_valid ? w_rd : 5'd0;
      end
   end

   assign o_result           = r_result;
   assign o_reg_write_enable = r_we;
   assign o_rd_addr          = r_rd;

endmodule

// File: rtl/fetch.sv
// Fetch stage: free-running PC, one instruction word latched per cycle.
// The fetch address travels with the word so AUIPC sees its own address.
module fetch
   import core_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_imem_addr,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc
);

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_instr_pc <= RESET_PC;
      end else begin
         r_pc       <= r_pc + PC_STEP;
         r_instr    <= i_imem_rdata;
         r_instr_pc <= r_pc;
      end
   end

   assign o_imem_addr = r_pc;
   assign o_pc        = r_pc;
   assign o_instr     = r_instr;
   assign o_instr_pc  = r_instr_pc;

endmodule

// File: rtl/fetch_decode_execute.sv
// Two-stage RV32I ALU core slice: fetch feeding decode/execute, no stalls,
// no forwarding needed since write-back lands on the edge that latches the next word.
module fetch_decode_execute
   import core_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_pc_out,
   output logic [31:0] o_instruction,
   output logic [31:0] o_result,
   output logic        o_reg_write_enable,
   output logic [4:0]  o_rd_addr
);

   logic [31:0] w_instr;
   logic [31:0] w_instr_pc;

   fetch u_fetch (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_imem_rdata (i_imem_rdata),
      .o_imem_addr  (o_imem_addr),
      .o_pc         (o_pc_out),
      .o_instr      (w_instr),
      .o_instr_pc   (w_instr_pc)
   );

   decode_execute u_decode_execute (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_instr            (w_instr),
      .i_instr_pc         (w_instr_pc),
      .o_result           (o_result),
      .o_reg_write_enable (o_reg_write_enable),
      .o_rd_addr          (o_rd_addr)
   );

   assign o_instruction = w_instr;

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Bench for fetch_decode_execute: directed scenarios plus a randomized program
// checked against an instruction-level model of the register file.
module tb_fetch_decode_execute;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_addr, imem_rdata, pc_out, instruction, result;
   logic        we;
   logic [4:0]  rd_addr;

   logic [31:0] mem   [0:1023];
   logic [31:0] mregs [0:31];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign imem_rdata = (imem_addr < 32'd1024) ? mem[imem_addr[9:0]] : 32'd0;

   fetch_decode_execute dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .o_imem_addr        (imem_addr),
      .i_imem_rdata       (imem_rdata),
      .o_pc_out           (pc_out),
      .o_instruction      (instruction),
      .o_result           (result),
      .o_reg_write_enable (we),
      .o_rd_addr          (rd_addr)
   );

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OP};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, OPIMM};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rd, opc};
   endfunction

   // Architectural meaning of one instruction given the model register file
   function automatic void model_exec(input logic [31:0] ins, input logic [31:0] pc,
                                      output logic v, output logic [31:0] res);
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [31:0] a, op2, imm;
      logic [4:0]  sh;
      logic        isimm;
      opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      a   = mregs[ins[19:15]];
      imm = {{20{ins[31]}}, ins[31:20]};
      isimm = (opc == OPIMM);
      op2 = isimm ? imm : mregs[ins[24:20]];
      sh  = op2[4:0];
      v = 1'b0; res = 32'd0;
      if (opc == LUI) begin
         v = 1'b1; res = {ins[31:12], 12'd0};
      end else if (opc == AUIPC) begin
         v = 1'b1; res = pc + {ins[31:12], 12'd0};
      end else if (opc == OP || isimm) begin
         case (f3)
            3'd0: if (isimm || f7 == 7'h00) begin v = 1'b1; res = a + op2; end
                  else if (f7 == 7'h20) begin v = 1'b1; res = a - op2; end
            3'd1: if (f7 == 7'h00) begin v = 1'b1; res = a << sh; end
            3'd2: if (isimm || f7 == 7'h00) begin v = 1'b1; res = ($signed(a) < $signed(op2)) ? 1 : 0; end
            3'd3: if (isimm || f7 == 7'h00) begin v = 1'b1; res = (a < op2) ? 1 : 0; end
            3'd4: if (isimm || f7 == 7'h00) begin v = 1'b1; res = a ^ op2; end
            3'd5: if (f7 == 7'h00) begin v = 1'b1; res = a >> sh; end
                  else if (f7 == 7'h20) begin v = 1'b1; res = $unsigned($signed(a) >>> sh); end
            3'd6: if (isimm || f7 == 7'h00) begin v = 1'b1; res = a | op2; end
            default: if (isimm || f7 == 7'h00) begin v = 1'b1; res = a & op2; end
         endcase
      end
   endfunction

   task automatic clear_mem;
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic reset_dut;
      rst_n = 1'b0; #2;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_reset;
      clear_mem();
      rst_n = 1'b0; #3;
      n_checks++; if (imem_addr !== 32'd0) begin n_errors++; $display("FAIL reset_imem_addr got %h exp 0", imem_addr); end
      n_checks++; if (pc_out !== 32'd0) begin n_errors++; $display("FAIL reset_pc_out got %h exp 0", pc_out); end
      n_checks++; if (instruction !== 32'd0) begin n_errors++; $display("FAIL reset_instr got %h exp 0", instruction); end
      n_checks++; if (result !== 32'd0) begin n_errors++; $display("FAIL reset_result got %h exp 0", result); end
      n_checks++; if (we !== 1'b0) begin n_errors++; $display("FAIL reset_we got %b exp 0", we); end
      n_checks++; if (rd_addr !== 5'd0) begin n_errors++; $display("FAIL reset_rd got %0d exp 0", rd_addr); end
   endtask

   task automatic test_fetch;
      clear_mem();
      mem[0] = 32'h11111111; mem[4] = 32'h22222222;
      reset_dut();
      tick();
      n_checks++; if (instruction !== 32'h11111111) begin n_errors++; $display("FAIL fetch_e1_instr got %h exp 11111111", instruction); end
      n_checks++; if (pc_out !== 32'd4) begin n_errors++; $display("FAIL fetch_e1_pc got %h exp 4", pc_out); end
      n_checks++; if (imem_addr !== 32'd4) begin n_errors++; $display("FAIL fetch_e1_addr got %h exp 4", imem_addr); end
      tick();
      n_checks++; if (instruction !== 32'h22222222) begin n_errors++; $display("FAIL fetch_e2_instr got %h exp 22222222", instruction); end
      n_checks++; if (pc_out !== 32'd8) begin n_errors++; $display("FAIL fetch_e2_pc got %h exp 8", pc_out); end
      n_checks++; if (we !== 1'b0) begin n_errors++; $display("FAIL fetch_e2_we got %b exp 0", we); end
      n_checks++; if (result !== 32'd0) begin n_errors++; $display("FAIL fetch_e2_result got %h exp 0", result); end
   endtask

   task automatic test_back_to_back;
      clear_mem();
      mem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
      mem[4] = enc_i(12'hFFD, 5'd1, 3'd0, 5'd2);
      reset_dut();
      tick(); tick();
      n_checks++; if (result !== 32'd5) begin n_errors++; $display("FAIL b2b_r1 got %h exp 5", result); end
      n_checks++; if (we !== 1'b1 || rd_addr !== 5'd1) begin n_errors++; $display("FAIL b2b_wr1 got we=%b rd=%0d exp we=1 rd=1", we, rd_addr); end
      tick();
      n_checks++; if (result !== 32'd2) begin n_errors++; $display("FAIL b2b_r2 got %h exp 2", result); end
      n_checks++; if (we !== 1'b1 || rd_addr !== 5'd2) begin n_errors++; $display("FAIL b2b_wr2 got we=%b rd=%0d exp we=1 rd=2", we, rd_addr); end
   endtask

   task automatic test_shifts_compare;
      logic [31:0] exp_v [4];
      exp_v = '{32'hC0000000, 32'h40000000, 32'd1, 32'd0};
      clear_mem();
      mem[0]  = enc_i(12'd1, 5'd0, 3'd0, 5'd1);
      mem[4]  = enc_i(12'd31, 5'd1, 3'd1, 5'd1);
      mem[8]  = enc_i(12'd1, 5'd0, 3'd0, 5'd2);
      mem[12] = enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3);
      mem[16] = enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd3);
      mem[20] = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd4);
      mem[24] = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd4);
      reset_dut();
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k >= 5) begin
            n_checks++;
            if (result !== exp_v[k-5]) begin n_errors++; $display("FAIL shift_cmp_%0d got %h exp %h", k-5, result, exp_v[k-5]); end
         end
      end
   endtask

   task automatic test_lui_auipc;
      clear_mem();
      mem[0] = enc_u(20'h12345, 5'd5, LUI);
      mem[4] = enc_i(12'd0, 5'd0, 3'd0, 5'd0);
      mem[8] = enc_u(20'h00001, 5'd6, AUIPC);
      reset_dut();
      tick(); tick();
      n_checks++; if (result !== 32'h12345000 || rd_addr !== 5'd5) begin n_errors++; $display("FAIL lui got %h rd=%0d exp 12345000 rd=5", result, rd_addr); end
      tick(); tick();
      n_checks++; if (result !== 32'h00001008 || rd_addr !== 5'd6) begin n_errors++; $display("FAIL auipc got %h rd=%0d exp 00001008 rd=6", result, rd_addr); end
   endtask

   task automatic test_x0;
      clear_mem();
      mem[0] = enc_i(12'd7, 5'd0, 3'd0, 5'd0);
      mem[4] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7);
      reset_dut();
      tick(); tick();
      n_checks++; if (we !== 1'b1 || rd_addr !== 5'd0) begin n_errors++; $display("FAIL x0_we got we=%b rd=%0d exp we=1 rd=0", we, rd_addr); end
      tick();
      n_checks++; if (result !== 32'd0 || we !== 1'b1) begin n_errors++; $display("FAIL x0_read got %h we=%b exp 0 we=1", result, we); end
   endtask

   task automatic test_midstream_reset;
      clear_mem();
      mem[0]  = enc_i(12'd1, 5'd0, 3'd0, 5'd11);
      mem[4]  = enc_i(12'h055, 5'd0, 3'd0, 5'd9);
      mem[8]  = enc_i(12'h066, 5'd0, 3'd0, 5'd10);
      mem[12] = enc_i(12'h077, 5'd0, 3'd0, 5'd11);
      reset_dut();
      tick(); tick(); tick(); tick();
      n_checks++; if (instruction !== mem[12] || we !== 1'b1) begin n_errors++; $display("FAIL mid_pre got %h we=%b exp %h we=1", instruction, we, mem[12]); end
      rst_n = 1'b0; #1;
      n_checks++; if (pc_out !== 32'd0 || imem_addr !== 32'd0) begin n_errors++; $display("FAIL mid_pc got %h/%h exp 0", pc_out, imem_addr); end
      n_checks++; if (instruction !== 32'd0 || result !== 32'd0) begin n_errors++; $display("FAIL mid_regs got %h/%h exp 0", instruction, result); end
      n_checks++; if (we !== 1'b0 || rd_addr !== 5'd0) begin n_errors++; $display("FAIL mid_ctrl got we=%b rd=%0d exp 0", we, rd_addr); end
      clear_mem();
      mem[0] = enc_r(7'h00, 5'd10, 5'd9, 3'd0, 5'd12);
      mem[4] = enc_r(7'h00, 5'd0, 5'd11, 3'd0, 5'd13);
      @(negedge clk); rst_n = 1'b1;
      tick();
      n_checks++; if (instruction !== mem[0] || pc_out !== 32'd4) begin n_errors++; $display("FAIL mid_restart got %h pc=%h exp %h pc=4", instruction, pc_out, mem[0]); end
      tick();
      n_checks++; if (result !== 32'h000000BB) begin n_errors++; $display("FAIL mid_kept got %h exp bb", result); end
      tick();
      n_checks++; if (result !== 32'd1) begin n_errors++; $display("FAIL mid_discard got %h exp 1", result); end
   endtask

   task automatic test_random;
      logic [31:0] prog[$];
      logic [31:0] ins, exp_res, exp_ins;
      logic [11:0] imm;
      logic [6:0]  f7;
      logic [4:0]  exp_rd;
      logic        v;
      int          sel;
      for (int r = 1; r < 32; r++) begin
         prog.push_back(enc_u(20'($urandom), 5'(r), LUI));
         prog.push_back(enc_i(12'($urandom), 5'(r), 3'd0, 5'(r)));
      end
      for (int n = 0; n < 120; n++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 3) begin
            f7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
            ins = enc_r(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
         end else if (sel <= 6) begin
            imm = 12'($urandom);
            if ($urandom_range(0, 3) != 0) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            ins = enc_i(imm, 5'($urandom), 3'($urandom), 5'($urandom));
         end else if (sel == 7) ins = enc_u(20'($urandom), 5'($urandom), LUI);
         else if (sel == 8)     ins = enc_u(20'($urandom), 5'($urandom), AUIPC);
         else                   ins = $urandom;
         prog.push_back(ins);
      end
      clear_mem();
      for (int i = 0; i < prog.size(); i++) mem[4*i] = prog[i];
      reset_dut();
      for (int k = 1; k <= prog.size() + 1; k++) begin
         tick();
         exp_ins = (k - 1 < prog.size()) ? prog[k-1] : 32'd0;
         n_checks++; if (instruction !== exp_ins) begin n_errors++; $display("FAIL rnd_instr e%0d got %h exp %h", k, instruction, exp_ins); end
         n_checks++; if (pc_out !== 32'(4*k)) begin n_errors++; $display("FAIL rnd_pc e%0d got %h exp %h", k, pc_out, 32'(4*k)); end
         if (k >= 2) begin
            ins = prog[k-2];
            model_exec(ins, 32'(4*(k-2)), v, exp_res);
            exp_rd = v ? ins[11:7] : 5'd0;
            if (v && exp_rd != 5'd0) mregs[exp_rd] = exp_res;
         end else begin
            v = 1'b0; exp_res = 32'd0; exp_rd = 5'd0;
         end
         n_checks++;
         if (result !== exp_res || we !== v || rd_addr !== exp_rd)
            begin n_errors++; $display("FAIL rnd_exec e%0d got %h we=%b rd=%0d exp %h we=%b rd=%0d", k, result, we, rd_addr, exp_res, v, exp_rd); end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      test_reset();
      test_fetch();
      test_back_to_back();
      test_shifts_compare();
      test_lui_auipc();
      test_x0();
      test_midstream_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
